// File: rtl/move_generator.sv
// Tic-tac-toe computer opponent: snapshots the board on request, then looks for a
// winning cell, then a blocking cell, then a preferred cell, and issues the move.
module move_generator #(
    parameter int DELAY = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [3:0] computer_position,
    output logic       pc,
    output logic       busy,
    output logic       no_move
);

    typedef enum logic [2:0] {
        IDLE,
        WIN_SCAN,
        BLK_SCAN,
        PREF,
        WAIT,
        ISSUE,
        FULL
    } state_t;

    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] PLAYER   = 2'b01;
    localparam logic [1:0] COMPUTER = 2'b10;

    localparam logic [7:0] WAIT_LAST  = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;
    localparam state_t     AFTER_PICK = (DELAY == 0) ? ISSUE : WAIT;

    // The eight winning lines as three parallel cell-index tables.
    localparam logic [3:0] LA [8] = '{4'd0, 4'd3, 4'd6, 4'd0, 4'd1, 4'd2, 4'd0, 4'd2};
    localparam logic [3:0] LB [8] = '{4'd1, 4'd4, 4'd7, 4'd3, 4'd4, 4'd5, 4'd4, 4'd4};
    localparam logic [3:0] LC [8] = '{4'd2, 4'd5, 4'd8, 4'd6, 4'd7, 4'd8, 4'd8, 4'd6};
    localparam logic [3:0] PRI [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

    state_t      state, next_state;
    logic [17:0] board, board_in;
    logic [3:0]  scan_idx, scan_idx_next;
    logic [3:0]  sel, sel_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic [3:0]  pref_idx;
    logic        any_empty;

    assign board_in = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

    // Cell i completes a line when both other cells of some line through it hold w.
    function automatic logic threat(input logic [17:0] b, input logic [3:0] i,
                                    input logic [1:0] w);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (LA[l] == i) hit = hit | (cell_of(b, LB[l]) == w && cell_of(b, LC[l]) == w);
            if (LB[l] == i) hit = hit | (cell_of(b, LA[l]) == w && cell_of(b, LC[l]) == w);
            if (LC[l] == i) hit = hit | (cell_of(b, LA[l]) == w && cell_of(b, LB[l]) == w);
        end
        return hit & (cell_of(b, i) == EMPTY);
    endfunction

    always_comb begin
        any_empty = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (cell_of(board_in, 4'(k)) == EMPTY) any_empty = 1'b1;
        end
    end

    // Walk the priority list backwards so the highest-priority empty cell wins.
    always_comb begin
        pref_idx = 4'd0;
        for (int p = 8; p >= 0; p--) begin
            if (cell_of(board, PRI[p]) == EMPTY) pref_idx = PRI[p];
        end
    end

    always_comb begin
        next_state    = state;
        scan_idx_next = scan_idx;
        sel_next      = sel;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    scan_idx_next = 4'd0;
                    next_state    = any_empty ? WIN_SCAN : FULL;
                end
            end
            WIN_SCAN: begin
                if (threat(board, scan_idx, COMPUTER)) begin
                    sel_next      = scan_idx;
                    wait_cnt_next = 8'd0;
                    next_state    = AFTER_PICK;
                end else if (scan_idx == 4'd8) begin
                    scan_idx_next = 4'd0;
                    next_state    = BLK_SCAN;
                end else begin
                    scan_idx_next = scan_idx + 4'd1;
                end
            end
            BLK_SCAN: begin
                if (threat(board, scan_idx, PLAYER)) begin
                    sel_next      = scan_idx;
                    wait_cnt_next = 8'd0;
                    next_state    = AFTER_PICK;
                end else if (scan_idx == 4'd8) begin
                    next_state = PREF;
                end else begin
                    scan_idx_next = scan_idx + 4'd1;
                end
            end
            PREF: begin
                sel_next      = pref_idx;
                wait_cnt_next = 8'd0;
                next_state    = AFTER_PICK;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) next_state = ISSUE;
                else                       wait_cnt_next = wait_cnt + 8'd1;
            end
            ISSUE:   next_state = IDLE;
            FULL:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            board             <= '0;
            scan_idx          <= '0;
            sel               <= '0;
            wait_cnt          <= '0;
            computer_position <= '0;
        end else begin
            state    <= next_state;
            scan_idx <= scan_idx_next;
            sel      <= sel_next;
            wait_cnt <= wait_cnt_next;
            if (state == IDLE && start) board <= board_in;
            if (next_state == ISSUE) computer_position <= sel_next;
        end
    end

    assign pc      = (state == ISSUE);
    assign no_move = (state == FULL);
    assign busy    = (state != IDLE);

endmodule
